// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
//   AW       : register address width
//   DW       : register data width
//   NREG     : number of architectural registers
//   ZERO_REG : hard-wired zero register; writes to it are dropped
//   wb_req_t : one pending writeback {rd, data}
package rf_pkg;

    localparam int AW   = 5;
    localparam int DW   = 64;
    localparam int NREG = 32;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order circular buffer of pending writebacks.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : store push_req at the tail this cycle
//   push_req   : request to store
//   pop        : retire the head entry this cycle (caller guarantees count != 0)
//   head_req   : current head entry
//   count      : occupancy
//   entries    : raw storage, indexed by slot
//   valid      : per-slot valid bits
//   head_ptr   : slot of the oldest entry; age of slot i is (i - head_ptr) mod DEPTH
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_req_t                    push_req,
    input  logic                       pop,
    output wb_req_t                    head_req,
    output logic [$clog2(DEPTH):0]     count,
    output wb_req_t [DEPTH-1:0]        entries,
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH)-1:0]   head_ptr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]        head_r;
    logic [PW-1:0]        tail_r;
    logic [CW-1:0]        count_r;
    logic [DEPTH-1:0]     valid_r;
    wb_req_t [DEPTH-1:0]  mem_r;

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
        end else begin
            if (pop) begin
                head_r          <= head_r + PW'(1);
                valid_r[head_r] <= 1'b0;
            end
            // Placed after the pop clear: when full, push and pop hit the same
            // slot and the new entry must stay valid.
            if (push) begin
                tail_r          <= tail_r + PW'(1);
                valid_r[tail_r] <= 1'b1;
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are only meaningful where valid is set.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[tail_r] <= push_req;
        end
    end

    assign head_req = mem_r[head_r];
    assign count    = count_r;
    assign entries  = mem_r;
    assign valid    = valid_r;
    assign head_ptr = head_r;

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback initiator for the register file: arbitrates load/ALU writeback
// requests (load first), queues them in order and drives the single
// register-file write port one entry per cycle. Pending values are forwarded
// to the two read addresses.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   mem_valid/rd/data, mem_ready    : load-unit writeback handshake
//   alu_valid/rd/data, alu_ready    : ALU writeback handshake
//   wb_hold                         : suppress issue while the write port is borrowed
//   RegWrite, writereg, writedata   : registered register-file write port
//   readreg1/2                      : read addresses presented to the register file
//   fwd_hit1/2, fwd_data1/2         : newest pending value for each read address
//   count                           : queue occupancy (output stage excluded)
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = rf_pkg::DW,
    parameter int AW    = rf_pkg::AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    input  logic                     wb_hold,
    output logic                     RegWrite,
    output logic [AW-1:0]            writereg,
    output logic [DW-1:0]            writedata,
    input  logic [AW-1:0]            readreg1,
    input  logic [AW-1:0]            readreg2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    import rf_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] data;
    } fwd_t;

    logic                 pop_s;
    logic                 space_s;
    logic                 mem_acc_s;
    logic                 alu_acc_s;
    logic                 push_s;
    wb_req_t              push_req_s;
    wb_req_t              head_req_s;
    wb_req_t [DEPTH-1:0]  entries_s;
    logic [DEPTH-1:0]     valid_s;
    logic [PW-1:0]        head_ptr_s;
    logic [CW-1:0]        count_s;
    fwd_t                 fwd1_s;
    fwd_t                 fwd2_s;

    // Newest pending value for rr. The output stage is oldest; queue slots are
    // then scanned oldest to youngest so a later match overrides an earlier one.
    function automatic fwd_t fwd_lookup(
        input logic [AW-1:0]        rr,
        input logic                 rw,
        input logic [AW-1:0]        wr,
        input logic [DW-1:0]        wd,
        input wb_req_t [DEPTH-1:0]  ents,
        input logic [DEPTH-1:0]     vld,
        input logic [PW-1:0]        hp
    );
        fwd_t          res;
        logic          en;
        logic          match;
        logic [PW-1:0] idx;
        en       = (rr != ZERO_REG);
        match    = en & rw & (wr == rr);
        res.hit  = match;
        res.data = match ? wd : {DW{1'b0}};
        for (int a = 0; a < DEPTH; a++) begin
            idx      = hp + PW'(a);
            match    = en & vld[idx] & (ents[idx].rd == rr);
            res.hit  = res.hit | match;
            res.data = match ? ents[idx].data : res.data;
        end
        return res;
    endfunction

    // Handshake: a slot frees up in the same cycle as a pop, so a full queue
    // still accepts while draining. Load requests always win the single slot.
    always_comb begin
        pop_s     = (count_s != CW'(0)) & ~wb_hold;
        space_s   = (count_s < CW'(DEPTH)) | pop_s;
        mem_ready = space_s;
        alu_ready = space_s & ~mem_valid;
        mem_acc_s = mem_valid & space_s;
        alu_acc_s = alu_valid & alu_ready;
        if (mem_valid) begin
            push_req_s.rd   = mem_rd;
            push_req_s.data = mem_data;
        end else begin
            push_req_s.rd   = alu_rd;
            push_req_s.data = alu_data;
        end
        // Writes to the zero register complete the handshake but are dropped.
        push_s = (mem_acc_s | alu_acc_s) & (push_req_s.rd != ZERO_REG);
    end

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .push_req (push_req_s),
        .pop      (pop_s),
        .head_req (head_req_s),
        .count    (count_s),
        .entries  (entries_s),
        .valid    (valid_s),
        .head_ptr (head_ptr_s)
    );

    // Output stage: register-file write port, loaded from the head on each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            writereg  <= '0;
            writedata <= '0;
        end else if (pop_s) begin
            RegWrite  <= 1'b1;
            writereg  <= head_req_s.rd;
            writedata <= head_req_s.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Forwarding search for both read ports.
    always_comb begin
        fwd1_s    = fwd_lookup(readreg1, RegWrite, writereg, writedata,
                               entries_s, valid_s, head_ptr_s);
        fwd2_s    = fwd_lookup(readreg2, RegWrite, writereg, writedata,
                               entries_s, valid_s, head_ptr_s);
        fwd_hit1  = fwd1_s.hit;
        fwd_data1 = fwd1_s.data;
        fwd_hit2  = fwd2_s.hit;
        fwd_data2 = fwd2_s.data;
    end

    assign count = count_s;

endmodule

// File: tb/tb_rf_wb_queue.sv
module tb_rf_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid, wb_hold;
    logic [4:0]  mem_rd, alu_rd, readreg1, readreg2;
    logic [63:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, RegWrite, fwd_hit1, fwd_hit2;
    logic [4:0]  writereg;
    logic [63:0] writedata, fwd_data1, fwd_data2;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_queue #(.DEPTH(4), .DW(64), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_hold(wb_hold),
        .RegWrite(RegWrite), .writereg(writereg), .writedata(writedata),
        .readreg1(readreg1), .readreg2(readreg2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;  logic [4:0] mrd; logic [63:0] md;
        logic        av;  logic [4:0] ard; logic [63:0] ad;
        logic        hold; logic [4:0] r1; logic [4:0] r2;
        logic        e_mrdy; logic e_ardy;
        logic        e_rw; logic [4:0] e_wr; logic [63:0] e_wd; logic [2:0] e_cnt;
        logic        e_h1; logic [63:0] e_d1; logic e_h2; logic [63:0] e_d2;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                         input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         input logic hold, input logic [4:0] r1, input logic [4:0] r2);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        wb_hold = hold; readreg1 = r1; readreg2 = r2;
    endtask

    task automatic idle(input logic hold, input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, hold, r1, r2);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          mv    mrd    md        av    ard     ad          hold  r1     r2      mrdy  ardy  rw    wr     wd       cnt   h1    d1       h2    d2
        tbl[0]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  64'h0,   3'd0, 1'b0, 64'h0,   1'b0, 64'h0};
        tbl[1]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd10, 64'd12,    1'b0, 5'd0,  5'd10, 1'b1, 1'b1, 1'b0, 5'd0,  64'h0,   3'd1, 1'b0, 64'h0,   1'b1, 64'd12};
        tbl[2]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd10, 1'b1, 1'b1, 1'b1, 5'd10, 64'd12,  3'd0, 1'b0, 64'h0,   1'b1, 64'd12};
        tbl[3]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd10, 1'b1, 1'b1, 1'b0, 5'd10, 64'd12,  3'd0, 1'b0, 64'h0,   1'b0, 64'h0};
        tbl[4]  = '{1'b1, 5'd12, 64'hAA,   1'b1, 5'd10, 64'h55,    1'b0, 5'd12, 5'd10, 1'b1, 1'b0, 1'b0, 5'd10, 64'd12,  3'd1, 1'b1, 64'hAA,  1'b0, 64'h0};
        tbl[5]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd10, 64'h55,    1'b0, 5'd12, 5'd10, 1'b1, 1'b1, 1'b1, 5'd12, 64'hAA,  3'd1, 1'b1, 64'hAA,  1'b1, 64'h55};
        tbl[6]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,     1'b0, 5'd12, 5'd10, 1'b1, 1'b1, 1'b1, 5'd10, 64'h55,  3'd0, 1'b0, 64'h0,   1'b1, 64'h55};
        tbl[7]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,     1'b0, 5'd12, 5'd10, 1'b1, 1'b1, 1'b0, 5'd10, 64'h55,  3'd0, 1'b0, 64'h0,   1'b0, 64'h0};
        tbl[8]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd0,  64'hFFFF,  1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd10, 64'h55,  3'd0, 1'b0, 64'h0,   1'b0, 64'h0};
        tbl[9]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd10, 64'h55,  3'd0, 1'b0, 64'h0,   1'b0, 64'h0};
        tbl[10] = '{1'b1, 5'd0,  64'h77,   1'b1, 5'd3,  64'd3,     1'b0, 5'd0,  5'd3,  1'b1, 1'b0, 1'b0, 5'd10, 64'h55,  3'd0, 1'b0, 64'h0,   1'b0, 64'h0};
        tbl[11] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,     1'b0, 5'd0,  5'd3,  1'b1, 1'b1, 1'b0, 5'd10, 64'h55,  3'd0, 1'b0, 64'h0,   1'b0, 64'h0};

        // Reset state
        rst = 1'b1;
        idle(1'b0, 5'd5, 5'd0);
        tick; tick;
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_writereg", 64'(writereg), 64'd0);
        chk("rst_writedata", writedata, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_fwd_hit1", 64'(fwd_hit1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mem_ready", 64'(mem_ready), 64'd1);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);

        // Table: single write, simultaneous requests, x0 discard
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].mv, tbl[i].mrd, tbl[i].md, tbl[i].av, tbl[i].ard, tbl[i].ad,
                  tbl[i].hold, tbl[i].r1, tbl[i].r2);
            #1;
            chk($sformatf("v%0d_mem_ready", i), 64'(mem_ready), 64'(tbl[i].e_mrdy));
            chk($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(tbl[i].e_ardy));
            tick;
            chk($sformatf("v%0d_regwrite", i), 64'(RegWrite), 64'(tbl[i].e_rw));
            chk($sformatf("v%0d_writereg", i), 64'(writereg), 64'(tbl[i].e_wr));
            chk($sformatf("v%0d_writedata", i), writedata, tbl[i].e_wd);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("v%0d_fwd_hit1", i), 64'(fwd_hit1), 64'(tbl[i].e_h1));
            chk($sformatf("v%0d_fwd_data1", i), fwd_data1, tbl[i].e_d1);
            chk($sformatf("v%0d_fwd_hit2", i), 64'(fwd_hit2), 64'(tbl[i].e_h2));
            chk($sformatf("v%0d_fwd_data2", i), fwd_data2, tbl[i].e_d2);
        end

        // Hold and fill: four accepted under hold, fifth stalls until a pop
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 64'h0, 1'b1, 5'(i), 64'(i * 100), 1'b1, 5'd0, 5'd0);
            #1;
            chk("fill_alu_ready", 64'(alu_ready), 64'd1);
            tick;
            chk("fill_count", 64'(count), 64'(i));
            chk("fill_regwrite", 64'(RegWrite), 64'd0);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'd500, 1'b1, 5'd0, 5'd0);
        #1;
        chk("full_alu_ready", 64'(alu_ready), 64'd0);
        chk("full_mem_ready", 64'(mem_ready), 64'd0);
        tick;
        chk("full_count", 64'(count), 64'd4);
        @(negedge clk);
        wb_hold = 1'b0;
        #1;
        chk("release_alu_ready", 64'(alu_ready), 64'd1);
        tick;
        chk("drain1_regwrite", 64'(RegWrite), 64'd1);
        chk("drain1_writereg", 64'(writereg), 64'd1);
        chk("drain1_writedata", writedata, 64'd100);
        chk("drain1_count", 64'(count), 64'd4);
        @(negedge clk);
        idle(1'b0, 5'd0, 5'd0);
        for (int k = 2; k <= 5; k++) begin
            tick;
            chk("drain_regwrite", 64'(RegWrite), 64'd1);
            chk("drain_writereg", 64'(writereg), 64'(k));
            chk("drain_writedata", writedata, 64'(k * 100));
            chk("drain_count", 64'(count), 64'(5 - k));
        end
        tick;
        chk("drain_end_regwrite", 64'(RegWrite), 64'd0);

        // Forwarding priority: two writes to x7, youngest wins
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 5'd8);
        tick;
        chk("fwd_first_hit1", 64'(fwd_hit1), 64'd1);
        chk("fwd_first_data1", fwd_data1, 64'h1);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h2, 1'b1, 5'd7, 5'd8);
        tick;
        chk("fwd_second_data1", fwd_data1, 64'h2);
        chk("fwd_second_count", 64'(count), 64'd2);
        chk("fwd_other_hit2", 64'(fwd_hit2), 64'd0);
        @(negedge clk);
        idle(1'b0, 5'd7, 5'd8);
        tick;
        chk("fwd_pop1_writedata", writedata, 64'h1);
        chk("fwd_pop1_hit1", 64'(fwd_hit1), 64'd1);
        chk("fwd_pop1_data1", fwd_data1, 64'h2);
        tick;
        chk("fwd_pop2_writedata", writedata, 64'h2);
        chk("fwd_pop2_data1", fwd_data1, 64'h2);
        tick;
        chk("fwd_done_hit1", 64'(fwd_hit1), 64'd0);
        chk("fwd_done_data1", fwd_data1, 64'h0);

        // Reset mid-operation, with the output stage busy
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 64'h0, 1'b1, 5'(20 + i), 64'(32'h20 + i), 1'b1, 5'd21, 5'd0);
            tick;
        end
        chk("mid_count", 64'(count), 64'd3);
        @(negedge clk);
        idle(1'b0, 5'd21, 5'd0);
        tick;
        chk("mid_regwrite", 64'(RegWrite), 64'd1);
        chk("mid_writereg", 64'(writereg), 64'd20);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("mrst_regwrite", 64'(RegWrite), 64'd0);
        chk("mrst_writereg", 64'(writereg), 64'd0);
        chk("mrst_writedata", writedata, 64'd0);
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_fwd_hit1", 64'(fwd_hit1), 64'd0);
        chk("mrst_fwd_data1", fwd_data1, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_mem_ready", 64'(mem_ready), 64'd1);
        chk("mrst_alu_ready", 64'(alu_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_regwrite", 64'(RegWrite), 64'd0);
            chk("post_rst_count", 64'(count), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
